// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. An accepted request loads both operands
//   into shift registers; one difference bit is produced per clock, LSB
//   first, through a full-subtractor cell with a one-bit borrow register.
//   After WIDTH bits the result and final borrow are registered and DONE
//   pulses for one cycle.
//
//   Build option:
//     SERSUB_SAT_EN  when defined, a result that ends with borrow=1 loads
//                    D=0 (unsigned saturating subtract). BOUT still reads 1.
//
//   Ports:
//     CLK    sole clock, rising edge
//     RST    asynchronous active-high reset
//     START  request, sampled only in IDLE
//     A, B   minuend / subtrahend, sampled on the accepting edge only
//     D      registered difference
//     BOUT   registered final borrow (1 = A < B)
//     BUSY   high while an operation is in progress
//     DONE   one-cycle pulse marking the update of D and BOUT
//
//   state | meaning
//   ------+----------------------------------------------------
//   IDLE  | waiting for START; D/BOUT hold the last result
//   RUN   | one bit processed per edge, WIDTH edges in total
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             BUSY,
  output logic             DONE
);

  // Counter must be able to hold WIDTH itself without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nxt;
  logic             diff_bit;
  logic             accept;
  logic             last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == RUN);

  // Full-subtractor cell on the current LSBs.
  assign diff_bit = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  // Difference bits enter at the MSB so that after WIDTH shifts bit 0 of
  // the result sits at bit 0 of r_sh.
  assign r_nxt    = {diff_bit, r_sh[WIDTH-1:1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nxt;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers only change on the completion edge, so an aborted
  // operation (reset mid-RUN) never disturbs them beyond the reset clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D    <= '0;
      BOUT <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= last;
      if (last) begin
        BOUT <= br_nxt;
`ifdef SERSUB_SAT_EN
        D    <= br_nxt ? '0 : r_nxt;
`else
        D    <= r_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start2;
  logic [7:0] a8, b8, d8;
  logic [1:0] a2, b2, d2;
  logic       bout8, busy8, done8;
  logic       bout2, busy2, done2;

  int vectors;
  int miscompares;
  logic [8:0] q8[$];   // {bout, d}
  logic [2:0] q2[$];
  logic [7:0] last_d8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8),
    .D(d8), .BOUT(bout8), .BUSY(busy8), .DONE(done8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .A(a2), .B(b2),
    .D(d2), .BOUT(bout2), .BUSY(busy2), .DONE(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, borrow is a simple comparison.
  function automatic logic [32:0] ref_sub(input int w, input int a, input int b);
    longint diff;
    logic   bo;
    bo   = (a < b);
    diff = longint'(a) - longint'(b);
    if (diff < 0) diff = diff + (longint'(1) << w);
`ifdef SERSUB_SAT_EN
    if (bo) diff = 0;
`endif
    return {bo, diff[31:0]};
  endfunction

  function automatic logic [8:0] exp8(input int a, input int b);
    logic [32:0] r;
    r = ref_sub(8, a, b);
    return {r[32], r[7:0]};
  endfunction

  function automatic logic [2:0] exp2(input int a, input int b);
    logic [32:0] r;
    r = ref_sub(2, a, b);
    return {r[32], r[1:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result whenever DONE is presented.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 1, 0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("d8", d8, e[7:0]);
        check("bout8", bout8, e[8]);
        check("busy8_at_done", busy8, 0);
        last_d8 = e[7:0];
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("done2_unexpected", 1, 0);
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        check("d2", d2, e[1:0]);
        check("bout2", bout2, e[2]);
      end
    end
  end

  // Called on the negedge right after the accepting edge; returns the number
  // of cycles until DONE and the number of cycles BUSY was high.
  task automatic wait_done8(output int n, output int nb);
    n  = 0;
    nb = busy8 ? 1 : 0;
    do begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
    end while (!done8 && n < 40);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n, nb;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    q8.push_back(exp8(a, b));
    @(negedge clk);
    start8 = 1'b0;
    // Operand changes after acceptance must not matter.
    a8 = 8'($urandom); b8 = 8'($urandom);
    check("d8_hold", d8, last_d8);
    wait_done8(n, nb);
    check("latency8", n, 8);
    check("busy8_cycles", nb, 8);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    int n;
    @(negedge clk);
    start2 = 1'b1; a2 = a; b2 = b;
    q2.push_back(exp2(a, b));
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done2 && n < 20);
    check("latency2", n, 2);
  endtask

  initial begin
    int n, nb;
    vectors = 0; miscompares = 0;
    last_d8 = '0;
    rst = 1'b1;
    start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;

    repeat (3) @(negedge clk);
    check("rst_d8", d8, 0);
    check("rst_bout8", bout8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);

    // START coincident with the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h21;
    q8.push_back(exp8(8'h5A, 8'h21));
    @(negedge clk);
    start8 = 1'b0;
    check("busy8_after_accept", busy8, 1);
    wait_done8(n, nb);
    check("latency8_first", n, 8);
    check("busy8_cycles_first", nb, 8);

    op8(8'h10, 8'h20);
    op8(8'hFF, 8'hFF);
    op8(8'h00, 8'h01);
    op8(8'h00, 8'hFF);
    op8(8'hFF, 8'h00);

    // Re-pulse during RUN is ignored; START held through DONE chains.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    q8.push_back(exp8(8'h80, 8'h01));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    q8.push_back(exp8(8'h12, 8'h34));
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("chain_first_done", done8, 1);
    @(negedge clk);
    start8 = 1'b0;
    check("chain_no_gap_busy", busy8, 1);
    wait_done8(n, nb);
    check("chain_latency", n, 8);

    // Reset mid-RUN aborts silently.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_d8", d8, 0);
    check("abort_bout8", bout8, 0);
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    last_d8 = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_d8_held", d8, 0);
    op8(8'h33, 8'h11);

    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom));

    for (int i = 0; i < 16; i++) op2(2'(i >> 2), 2'(i & 3));

    repeat (5) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
